// File: rtl/axis_stall_sig_generator.sv
// axis_stall_sig_generator: per-channel AXI-Stream stall detector driving axis_block_sigs
// Ports: clock, reset (sync, active-high), enable, ch_tvalid/ch_tready [NUM_CH] in;
//   axis_block_sigs [NUM_CH], any_block, block_cnt [$clog2(NUM_CH+1)] out.
// Define AXIS_STALL_CAPTURE_EN to add first_block_valid / first_block_idx (sticky first-block capture).
module axis_stall_sig_generator #(
  parameter int NUM_CH = 12,
  parameter int STALL_CYCLES = 16,
  parameter logic [NUM_CH-1:0] CONSUMER_MASK = 12'h0FF,
  parameter int CNT_W = 16
)(
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic [NUM_CH-1:0] ch_tvalid,
  input  logic [NUM_CH-1:0] ch_tready,
  output logic [NUM_CH-1:0] axis_block_sigs,
  output logic any_block,
  output logic [$clog2(NUM_CH+1)-1:0] block_cnt
`ifdef AXIS_STALL_CAPTURE_EN
  ,
  output logic first_block_valid,
  output logic [$clog2(NUM_CH)-1:0] first_block_idx
`endif
);
  localparam int BW = $clog2(NUM_CH+1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STALL_CYCLES-1);
  typedef enum logic [1:0] {IDLE, STALL, BLOCKED} state_t;
  state_t state_q [NUM_CH];
  state_t state_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [CNT_W-1:0] cnt_d [NUM_CH];
  logic [NUM_CH-1:0] stall, go, blk_d;
  logic [BW-1:0] cnt_sum;
  assign stall = (CONSUMER_MASK & ch_tready & ~ch_tvalid) | (~CONSUMER_MASK & ch_tvalid & ~ch_tready);
  assign go = stall & {NUM_CH{enable}};
  always_comb begin
    cnt_sum = '0;
    blk_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = !go[i] ? IDLE :
                   (state_q[i] == BLOCKED || (state_q[i] == STALL && cnt_q[i] == LAST) ||
                    (state_q[i] == IDLE && STALL_CYCLES == 1)) ? BLOCKED : STALL;
      cnt_d[i] = !go[i] ? '0 : state_q[i] == BLOCKED ? cnt_q[i] : state_q[i] == IDLE ? ONE : cnt_q[i] + ONE;
      blk_d[i] = state_d[i] == BLOCKED;
      cnt_sum = cnt_sum + BW'(blk_d[i]);
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= '{default: IDLE};
      cnt_q <= '{default: '0};
      axis_block_sigs <= '0;
      any_block <= 1'b0;
      block_cnt <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      axis_block_sigs <= blk_d;
      any_block <= |blk_d;
      block_cnt <= cnt_sum;
    end
  end
`ifdef AXIS_STALL_CAPTURE_EN
  localparam int IW = $clog2(NUM_CH);
  logic [NUM_CH-1:0] new_blk;
  logic [IW-1:0] idx_d;
  always_comb begin
    new_blk = blk_d & ~axis_block_sigs;
    idx_d = '0;
    for (int i = NUM_CH-1; i >= 0; i--) if (new_blk[i]) idx_d = IW'(i);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      first_block_valid <= 1'b0;
      first_block_idx <= '0;
    end else if (!first_block_valid && |new_blk) begin
      first_block_valid <= 1'b1;
      first_block_idx <= idx_d;
    end
  end
`endif
endmodule

// File: tb/tb_axis_stall_sig_generator.sv
// tb_axis_stall_sig_generator: randomized + directed self-checking bench with a run-length reference model
module tb_axis_stall_sig_generator;
  localparam logic [11:0] MASK = 12'h0FF;
  logic clock, reset, enable;
  logic [11:0] ch_tvalid, ch_tready;
  logic [11:0] sig16, sig1;
  logic any16, any1;
  logic [3:0] bc16, bc1;
  int checks = 0, failures = 0;
  int run [12];
  int sc [2] = '{16, 1};
  bit fv [2];
  int fidx [2];
  int rem [12];
  bit mode [12];

  axis_stall_sig_generator #(.NUM_CH(12), .STALL_CYCLES(16), .CONSUMER_MASK(12'h0FF), .CNT_W(16)) u16 (
    .clock(clock), .reset(reset), .enable(enable), .ch_tvalid(ch_tvalid), .ch_tready(ch_tready),
    .axis_block_sigs(sig16), .any_block(any16), .block_cnt(bc16)
`ifdef AXIS_STALL_CAPTURE_EN
    , .first_block_valid(fbv16), .first_block_idx(fbi16)
`endif
  );
  axis_stall_sig_generator #(.NUM_CH(12), .STALL_CYCLES(1), .CONSUMER_MASK(12'h0FF), .CNT_W(16)) u1 (
    .clock(clock), .reset(reset), .enable(enable), .ch_tvalid(ch_tvalid), .ch_tready(ch_tready),
    .axis_block_sigs(sig1), .any_block(any1), .block_cnt(bc1)
`ifdef AXIS_STALL_CAPTURE_EN
    , .first_block_valid(fbv1), .first_block_idx(fbi1)
`endif
  );
`ifdef AXIS_STALL_CAPTURE_EN
  logic fbv16, fbv1;
  logic [3:0] fbi16, fbi1;
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] flags(input int n);
    logic [11:0] f;
    for (int i = 0; i < 12; i++) f[i] = run[i] >= n;
    return f;
  endfunction

  task automatic step();
    logic [11:0] prev [2];
    logic [11:0] nb;
    bit st;
    @(posedge clock);
    for (int k = 0; k < 2; k++) prev[k] = flags(sc[k]);
    if (reset) begin
      for (int i = 0; i < 12; i++) run[i] = 0;
      fv = '{0, 0};
      fidx = '{0, 0};
    end else begin
      for (int i = 0; i < 12; i++) begin
        st = MASK[i] ? (ch_tready[i] && !ch_tvalid[i]) : (ch_tvalid[i] && !ch_tready[i]);
        run[i] = (enable && st) ? (run[i] < 1000 ? run[i] + 1 : run[i]) : 0;
      end
      for (int k = 0; k < 2; k++) begin
        nb = flags(sc[k]) & ~prev[k];
        if (!fv[k] && nb != 0) begin
          fv[k] = 1;
          for (int j = 11; j >= 0; j--) if (nb[j]) fidx[k] = j;
        end
      end
    end
    #1;
    check("sigs16", 32'(sig16), 32'(flags(16)));
    check("any16", 32'(any16), 32'(|flags(16)));
    check("cnt16", 32'(bc16), 32'($countones(flags(16))));
    check("sigs1", 32'(sig1), 32'(flags(1)));
    check("any1", 32'(any1), 32'(|flags(1)));
    check("cnt1", 32'(bc1), 32'($countones(flags(1))));
`ifdef AXIS_STALL_CAPTURE_EN
    check("fbv16", 32'(fbv16), 32'(fv[0]));
    check("fbi16", 32'(fbi16), 32'(fidx[0]));
    check("fbv1", 32'(fbv1), 32'(fv[1]));
    check("fbi1", 32'(fbi1), 32'(fidx[1]));
`endif
  endtask

  task automatic set_ch(input int i, input bit st);
    int k;
    if (st) begin
      ch_tvalid[i] = ~MASK[i];
      ch_tready[i] = MASK[i];
    end else begin
      k = $urandom_range(0, 2);
      ch_tvalid[i] = k == 1 ? 1'b1 : k == 2 ? MASK[i] : 1'b0;
      ch_tready[i] = k == 1 ? 1'b1 : k == 2 ? ~MASK[i] : 1'b0;
    end
  endtask

  task automatic idle_all();
    for (int i = 0; i < 12; i++) set_ch(i, 0);
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  initial begin
    for (int i = 0; i < 12; i++) run[i] = 0;
    reset = 1'b1;
    enable = 1'b1;
    ch_tvalid = '0;
    ch_tready = '0;
    steps(2);
    check("rst_sigs", 32'(sig16), 32'h0);
    check("rst_any", 32'(any16), 32'h0);
    check("rst_cnt", 32'(bc16), 32'h0);
    reset = 1'b0;
    idle_all();
    steps(2);
    set_ch(9, 1);
    steps(15);
    check("ch9_15", 32'(sig16), 32'h0);
    steps(1);
    check("ch9_16", 32'(sig16), 32'h200);
    check("ch9_any", 32'(any16), 32'h1);
    check("ch9_cnt", 32'(bc16), 32'h1);
    idle_all();
    steps(1);
    check("ch9_clr", 32'(sig16), 32'h0);
    set_ch(0, 1);
    steps(20);
    check("ch0_20", 32'(sig16[0]), 32'h1);
    ch_tvalid[0] = 1'b1;
    steps(1);
    check("ch0_hs", 32'(sig16[0]), 32'h0);
    idle_all();
    steps(1);
    set_ch(0, 1);
    steps(5);
    check("ch0_5", 32'(sig16[0]), 32'h0);
    idle_all();
    reset = 1'b1;
    steps(1);
    reset = 1'b0;
    set_ch(2, 1);
    set_ch(5, 1);
    steps(16);
    check("ch25", 32'(sig16), 32'h024);
    check("ch25_cnt", 32'(bc16), 32'h2);
    idle_all();
    steps(1);
    set_ch(3, 1);
    steps(10);
    enable = 1'b0;
    steps(1);
    enable = 1'b1;
    steps(15);
    check("ch3_15", 32'(sig16[3]), 32'h0);
    steps(1);
    check("ch3_16", 32'(sig16[3]), 32'h1);
    idle_all();
    steps(1);
    set_ch(1, 1);
    set_ch(4, 1);
    set_ch(7, 1);
    steps(16);
    check("ch147", 32'(sig16), 32'h092);
    reset = 1'b1;
    steps(1);
    reset = 1'b0;
    check("ch147_rst", 32'({sig16, any16, bc16}), 32'h0);
    steps(15);
    check("ch147_15", 32'(sig16), 32'h0);
    steps(1);
    check("ch147_16", 32'(sig16), 32'h092);
    idle_all();
    steps(1);
    set_ch(11, 1);
    steps(1);
    check("sc1_ch11", 32'(sig1), 32'h800);
    set_ch(11, 0);
    steps(1);
    check("sc1_clr", 32'(sig1), 32'h0);
    for (int i = 0; i < 12; i++) rem[i] = 0;
    repeat (3000) begin
      for (int i = 0; i < 12; i++) begin
        if (rem[i] == 0) begin
          mode[i] = 1'($urandom_range(0, 1));
          rem[i] = $urandom_range(1, 24);
        end
        rem[i]--;
        set_ch(i, mode[i]);
      end
      enable = $urandom_range(0, 31) != 0;
      reset = $urandom_range(0, 499) == 0;
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axis_stall_sig_generator.md
Name: axis_stall_sig_generator

Overview:
- Per-channel AXI-Stream stall detector for the HLS co-simulation deadlock infrastructure.
- Watches tvalid/tready of every stream port on a dataflow process and produces the axis_block_sigs vector consumed by the deadlock monitors.
- A channel is flagged blocked only after its stall condition persists for STALL_CYCLES consecutive cycles.
- Sits between the testbench stream interfaces and the monitor tree: it is the producing end of axis_block_sigs.

Parameters:
- NUM_CH, 12, number of monitored stream channels; width of axis_block_sigs.
- STALL_CYCLES, 16, consecutive stall cycles required to flag a channel; legal range 1 to 65535.
- CONSUMER_MASK, 12'h0FF, per-channel direction. Bit=1: the block reads the channel (stall = tready & ~tvalid). Bit=0: the block writes the channel (stall = tvalid & ~tready).
- CNT_W, 16, stall counter width; must satisfy 2^CNT_W > STALL_CYCLES.

Ports:
- clock  in  1  clock
- reset  in  1  reset
- enable  in  1  1 = monitoring active; 0 = all channels forced to IDLE.
- ch_tvalid  in  NUM_CH  per-channel tvalid.
- ch_tready  in  NUM_CH  per-channel tready.
- axis_block_sigs  out  NUM_CH  registered per-channel blocked flag.
- any_block  out  1  registered OR of the next-state axis_block_sigs; asserts on the same edge as the flag.
- block_cnt  out  $clog2(NUM_CH+1)  registered number of channels in BLOCKED.

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clock.
- Reset values: axis_block_sigs=0, any_block=0, block_cnt=0, every counter=0, every channel state=IDLE.
- Stall condition per channel i:
  - stall_i = CONSUMER_MASK[i] ? (ch_tready[i] & ~ch_tvalid[i]) : (ch_tvalid[i] & ~ch_tready[i]).
  - Handshake (tvalid & tready) is never a stall.
  - Both tvalid and tready low is never a stall.
- Per-channel FSM, states IDLE, STALL, BLOCKED, evaluated each rising edge:
  - IDLE: stall_i & enable → STALL with cnt=1. If STALL_CYCLES==1 → BLOCKED directly. Otherwise stay IDLE with cnt=0.
  - STALL: ~stall_i or ~enable → IDLE with cnt=0. stall_i with cnt==STALL_CYCLES-1 → BLOCKED. Otherwise cnt+1.
  - BLOCKED: cnt holds (saturated, no wrap). ~stall_i or ~enable → IDLE with cnt=0.
- axis_block_sigs[i] is 1 exactly while state==BLOCKED. It is registered with the state, with no extra pipeline stage.
- Latency:
  - The flag rises at the STALL_CYCLES-th consecutive rising edge that samples stall_i=1.
  - It falls at the first edge that samples stall_i=0.
- block_cnt is the popcount of the next-state vector, so it is always consistent with axis_block_sigs in the same cycle.
- Channels are fully independent. Simultaneous transitions on several channels are all applied in the same cycle.
- Reset mid-operation wins over every other input. enable low mid-count discards partial counts; a later stall restarts from 1.
- Counters never wrap. X on ch_tvalid or ch_tready while enable=1 is a bench error; no special handling is required.

Optional Feature:
- AXIS_STALL_CAPTURE_EN defined adds two ports:
  - first_block_valid  out  1
  - first_block_idx  out  $clog2(NUM_CH)
- On the first edge where any channel enters BLOCKED while first_block_valid=0:
  - first_block_valid becomes 1 and first_block_idx latches the lowest newly-blocked index.
  - Both are sticky until reset; enable has no effect on them.
  - Reset values are 0 and 0.
- Undefined: the ports are absent and no capture logic is built. All other behaviour is identical.

Test Plan:
- Writer channel 9 (CONSUMER_MASK bit 0), tvalid=1, tready=0 for 16 cycles → axis_block_sigs=12'h200 after the 16th edge, any_block=1, block_cnt=1. At 15 stall cycles the flag is still 0.
- Reader channel 0, tready=1, tvalid=0 for 20 cycles, then tvalid=1 for one cycle → flag high from cycle 16. The flag clears at the edge that samples the handshake. A new 5-cycle stall leaves the flag at 0.
- Channels 2 and 5 stall together for 16 cycles → 12'h024 on the same edge, block_cnt=2. With AXIS_STALL_CAPTURE_EN: first_block_idx=2, first_block_valid=1.
- Channel 3 stalls for 10 cycles, enable=0 for 1 cycle, then stalls again → the flag requires 16 more stall cycles after enable returns high.
- Channels 1, 4 and 7 blocked, then reset pulsed for 1 cycle with stalls still present → all outputs 0 the cycle after reset. The flags reassert 16 cycles after reset deasserts.
- STALL_CYCLES=1 build, channel 11 stalls for a single cycle → axis_block_sigs=12'h800 on that edge, cleared on the next non-stall edge.
